midi_poly_voice_alloc: RTL and testbench
========================================

Name: midi_poly_voice_alloc

Overview:
- MIDI byte-stream interpreter plus 4-voice polyphonic note allocator; sits between the UART/MIDI receiver and the oscillator/envelope voices.
- Decodes Note On, Note Off and Program Change on one selectable channel.
- Assigns incoming notes to the lowest free of four voice slots and frees slots on Note Off.

Parameters:
- VOICES, 4, number of voice slots. Fixed at 4: outputs are explicit per-voice ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ce  in  1  clock enable. All state updates only when ce=1.
- channel  in  4  MIDI channel to accept, 0-15.
- data  in  8  received MIDI byte.
- dv  in  1  data valid. One byte is accepted per clk edge with dv=1 and ce=1.
- note_num  out  7  last decoded note number.
- note_vel  out  7  last decoded velocity.
- program  out  7  last Program Change value.
- note_on_out  out  1  one-cycle pulse when a Note On is decoded.
- note_off_out  out  1  one-cycle pulse when a Note Off is decoded.
- note_num_0..note_num_3  out  7 each  note held by voice 0..3.
- note_vel_0..note_vel_3  out  7 each  velocity of voice 0..3. 0 means the voice is free.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, the parser is in IDLE, running status is cleared, all voices are free.
- Byte classification:
  - Bit7=1 is a status byte; bit7=0 is a data byte (7-bit value).
  - Bytes 0xF8-0xFF (realtime) are ignored and leave parser state untouched.
  - Bytes 0xF0-0xF7 clear running status and return the parser to IDLE.
- Status handling:
  - 0x9n or 0x8n with n=channel goes to state NUM. The message type is latched.
  - 0xCn with n=channel goes to state PROG.
  - Any other status byte, including other channels, goes to IDLE and clears running status.
- State transitions:
  - IDLE: data bytes are ignored.
  - NUM: a data byte latches the note number and moves to VEL.
  - VEL: a data byte latches the velocity; the parser returns to NUM (running status).
  - PROG: a data byte updates program and stays in PROG (running status).
- Event decode:
  - On the edge accepting the velocity byte, note_num and note_vel are registered.
  - Exactly one of note_on_out or note_off_out is high for the next single cycle.
  - 0x9n with velocity 0 is a Note Off.
  - A Note Off updates note_num and note_vel to the received values.
- Event pulses: high for exactly one clk cycle (one ce-qualified cycle), then low. With ce=0 they hold.
- Voice allocator (updates on the edge where note_on_out or note_off_out is sampled high, i.e. one cycle after the pulse appears):
  - Note On where some voice has vel≠0 and the same num: retrigger that voice (velocity replaced, no new slot).
  - Otherwise the lowest-index voice with vel=0 gets num and vel.
  - If no voice is free, the note is dropped; no voice changes.
  - Note Off: the voice with vel≠0 and matching num is cleared (num=0, vel=0).
  - A Note Off for a note not held is ignored.
  - Voices are only ever cleared by Note Off or reset; there is no stealing.
- Latency: voice outputs reflect a message 2 clk cycles after the velocity byte is accepted.
- Reset mid-message: the partial message is discarded and voices are cleared.
- dv held high for multiple cycles counts as multiple bytes; the source must pulse it.

Test Plan:
- Reset → all outputs 0. After release, bytes 0x90,10,127 → note_on_out one-cycle pulse, note_num=10, note_vel=127, then note_num_0=10 and note_vel_0=127.
- Sequential Note Ons 0x90 10/11/12/13 vel 127 → voices 0..3 hold 10,11,12,13, all vel 127. A fifth 0x90,15,127 → pulse occurs, voices unchanged.
- From the full state: 0x80,10,127 → note_off_out pulse; voice 0 becomes num 0, vel 0. Then 0x90,14,127 → voice 0 = 14/127; voices 1-3 unchanged.
- Running status and vel-0 off: 0x90,20,100,21,90 → voices hold 20 and 21. Then 0x90,20,0 (running 20,0) → note_off_out pulse and voice holding 20 freed.
- Channel filtering: channel=0, bytes 0x91,30,127 → no pulses, no voice change. 0xC0,5 → program=5. 0xF8 inserted mid-message → message still decodes correctly.
- ce=0 during bytes → nothing accepted. Assert rst between the note byte and the velocity byte → outputs 0; a subsequent bare data byte is ignored.

Source files
------------

// File: rtl/midi_poly_voice_alloc.sv
// midi_poly_voice_alloc
//   Interprets a MIDI byte stream on one selectable channel (Note On, Note Off,
//   Program Change, running status) and allocates decoded notes to four voice
//   slots. Each note goes to the lowest free slot. A held note is retriggered
//   in place. Note Off frees the slot. No voice stealing.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   ce             clock enable; all state advances only when high
//   channel[3:0]   MIDI channel to accept
//   data[7:0]      received MIDI byte, qualified by dv
//   dv             data valid, one byte per ce-qualified edge
//   note_num[6:0]  last decoded note number
//   note_vel[6:0]  last decoded velocity
//   program_num[6:0]  last Program Change value ("program" is a reserved word)
//   note_on_out    one-cycle pulse on a decoded Note On
//   note_off_out   one-cycle pulse on a decoded Note Off
//   note_num_0..3  note held by voice 0..3
//   note_vel_0..3  velocity of voice 0..3 (0 = voice free)

module midi_poly_voice_alloc #(
    parameter int unsigned VOICES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [3:0] channel,
    input  logic [7:0] data,
    input  logic       dv,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic [6:0] program_num,
    output logic       note_on_out,
    output logic       note_off_out,
    output logic [6:0] note_num_0,
    output logic [6:0] note_num_1,
    output logic [6:0] note_num_2,
    output logic [6:0] note_num_3,
    output logic [6:0] note_vel_0,
    output logic [6:0] note_vel_1,
    output logic [6:0] note_vel_2,
    output logic [6:0] note_vel_3
);

    localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NUM,
        S_VEL,
        S_PROG
    } state_t;

    state_t state, state_nxt;

    logic       msg_on;      // latched message type: 1 = 0x9n, 0 = 0x8n
    logic [6:0] cur_num;     // note number waiting for its velocity byte

    logic accept, is_rt, is_note_st, is_prog_st;
    logic take_num, take_vel, take_prog, latch_type;
    logic ev_on, ev_off;

    // Byte classification
    always_comb begin
        accept     = ce & dv;
        is_rt      = (data[7:3] == 5'b11111);
        is_note_st = ((data[7:4] == 4'h9) || (data[7:4] == 4'h8)) &&
                     (data[3:0] == channel);
        is_prog_st = (data[7:4] == 4'hC) && (data[3:0] == channel);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Realtime bytes never touch the parser; any status byte
    // that is not ours (including system common) drops running status.
    always_comb begin
        state_nxt = state;
        if (accept && !is_rt) begin
            if (data[7]) begin
                if (is_note_st) begin
                    state_nxt = S_NUM;
                end else if (is_prog_st) begin
                    state_nxt = S_PROG;
                end else begin
                    state_nxt = S_IDLE;
                end
            end else begin
                case (state)
                    S_NUM:   state_nxt = S_VEL;
                    S_VEL:   state_nxt = S_NUM;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Output / event decode
    always_comb begin
        latch_type = accept & is_note_st;
        take_num   = accept & ~data[7] & (state == S_NUM);
        take_vel   = accept & ~data[7] & (state == S_VEL);
        take_prog  = accept & ~data[7] & (state == S_PROG);
        ev_on      = take_vel & msg_on & (data[6:0] != 7'd0);
        ev_off     = take_vel & ~ev_on;
    end

    // Parser datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_on       <= 1'b0;
            cur_num      <= '0;
            note_num     <= '0;
            note_vel     <= '0;
            program_num  <= '0;
            note_on_out  <= 1'b0;
            note_off_out <= 1'b0;
        end else if (ce) begin
            if (latch_type) begin
                msg_on <= data[4];
            end
            if (take_num) begin
                cur_num <= data[6:0];
            end
            if (take_vel) begin
                note_num <= cur_num;
                note_vel <= data[6:0];
            end
            if (take_prog) begin
                program_num <= data[6:0];
            end
            note_on_out  <= ev_on;
            note_off_out <= ev_off;
        end
    end

    // Voice allocator
    logic [6:0]       v_num [VOICES];
    logic [6:0]       v_vel [VOICES];
    logic             hit, free_found;
    logic [IDX_W-1:0] hit_idx, free_idx;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!hit && (v_vel[i] != 7'd0) && (v_num[i] == note_num)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free_found && (v_vel[i] == 7'd0)) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Acts on the registered event, one cycle after the pulse rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                v_num[i] <= '0;
                v_vel[i] <= '0;
            end
        end else if (ce) begin
            if (note_on_out) begin
                if (hit) begin
                    v_vel[hit_idx] <= note_vel;
                end else if (free_found) begin
                    v_num[free_idx] <= note_num;
                    v_vel[free_idx] <= note_vel;
                end
            end else if (note_off_out && hit) begin
                v_num[hit_idx] <= '0;
                v_vel[hit_idx] <= '0;
            end
        end
    end

    always_comb begin
        note_num_0 = v_num[0];
        note_num_1 = v_num[1];
        note_num_2 = v_num[2];
        note_num_3 = v_num[3];
        note_vel_0 = v_vel[0];
        note_vel_1 = v_vel[1];
        note_vel_2 = v_vel[2];
        note_vel_3 = v_vel[3];
    end

endmodule

// File: tb/tb_midi_poly_voice_alloc.sv
// Self-checking bench for midi_poly_voice_alloc. Expected note events are
// queued when the velocity byte is driven and compared when a pulse appears.

module tb_midi_poly_voice_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b1;
    logic [3:0] channel = 4'd0;
    logic [7:0] data = 8'd0;
    logic       dv = 1'b0;
    logic [6:0] note_num, note_vel, program_num;
    logic       note_on_out, note_off_out;
    logic [6:0] note_num_0, note_num_1, note_num_2, note_num_3;
    logic [6:0] note_vel_0, note_vel_1, note_vel_2, note_vel_3;

    midi_poly_voice_alloc #(.VOICES(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .channel(channel), .data(data), .dv(dv),
        .note_num(note_num), .note_vel(note_vel), .program_num(program_num),
        .note_on_out(note_on_out), .note_off_out(note_off_out),
        .note_num_0(note_num_0), .note_num_1(note_num_1),
        .note_num_2(note_num_2), .note_num_3(note_num_3),
        .note_vel_0(note_vel_0), .note_vel_1(note_vel_1),
        .note_vel_2(note_vel_2), .note_vel_3(note_vel_3)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       on;
        bit [6:0] num;
        bit [6:0] vel;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Event monitor: pops on each new pulse, then checks the pulse drops
    // after one ce-qualified edge.
    logic ce_at_edge = 1'b1;
    logic prev_pulse = 1'b0;
    always @(posedge clk) ce_at_edge <= ce;

    always @(negedge clk) begin
        logic pulse;
        ev_t  e;
        pulse = note_on_out | note_off_out;
        if (!rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (pulse && !prev_pulse) begin
                chk("pulse_both", {31'd0, note_on_out & note_off_out}, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_type_on", {31'd0, note_on_out}, {31'd0, e.on});
                    chk("ev_num", {25'd0, note_num}, {25'd0, e.num});
                    chk("ev_vel", {25'd0, note_vel}, {25'd0, e.vel});
                end
            end else if (prev_pulse && ce_at_edge) begin
                chk("pulse_width", {31'd0, pulse}, 0);
            end
            prev_pulse = pulse;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data = b;
        dv   = 1'b1;
        @(negedge clk);
        dv   = 1'b0;
    endtask

    task automatic expect_ev(input bit on, input bit [6:0] num, input bit [6:0] vel);
        ev_t e;
        e.on  = on;
        e.num = num;
        e.vel = vel;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_voice(input int idx, input int unsigned num, input int unsigned vel);
        logic [6:0] n, v;
        case (idx)
            0: begin n = note_num_0; v = note_vel_0; end
            1: begin n = note_num_1; v = note_vel_1; end
            2: begin n = note_num_2; v = note_vel_2; end
            default: begin n = note_num_3; v = note_vel_3; end
        endcase
        chk($sformatf("voice%0d_num", idx), {25'd0, n}, num);
        chk($sformatf("voice%0d_vel", idx), {25'd0, v}, vel);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_note_num"}, {25'd0, note_num}, 0);
        chk({tag, "_note_vel"}, {25'd0, note_vel}, 0);
        chk({tag, "_program"}, {25'd0, program_num}, 0);
        chk({tag, "_on"}, {31'd0, note_on_out}, 0);
        chk({tag, "_off"}, {31'd0, note_off_out}, 0);
        for (int i = 0; i < 4; i++) chk_voice(i, 0, 0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #2 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        do_reset();

        // Single Note On
        send_byte(8'h90);
        send_byte(8'd10);
        expect_ev(1, 10, 127);
        send_byte(8'd127);
        idle(3);
        chk_voice(0, 10, 127);

        // Fill all voices via running status, then a fifth note is dropped
        for (int n = 11; n <= 13; n++) begin
            send_byte(8'(n));
            expect_ev(1, 7'(n), 127);
            send_byte(8'd127);
        end
        send_byte(8'h90);
        send_byte(8'd15);
        expect_ev(1, 15, 127);
        send_byte(8'd127);
        idle(3);
        for (int i = 0; i < 4; i++) chk_voice(i, 10 + i, 127);

        // Note Off frees voice 0, next Note On reuses it
        send_byte(8'h80);
        send_byte(8'd10);
        expect_ev(0, 10, 127);
        send_byte(8'd127);
        idle(3);
        chk_voice(0, 0, 0);
        send_byte(8'h90);
        send_byte(8'd14);
        expect_ev(1, 14, 127);
        send_byte(8'd127);
        idle(3);
        chk_voice(0, 14, 127);
        for (int i = 1; i < 4; i++) chk_voice(i, 10 + i, 127);

        // Retrigger of a held note replaces velocity only
        send_byte(8'd12);
        expect_ev(1, 12, 60);
        send_byte(8'd60);
        idle(3);
        chk_voice(2, 12, 60);
        chk_voice(3, 13, 127);

        // Running status and velocity-0 Note Off
        do_reset();
        send_byte(8'h90);
        send_byte(8'd20);
        expect_ev(1, 20, 100);
        send_byte(8'd100);
        send_byte(8'd21);
        expect_ev(1, 21, 90);
        send_byte(8'd90);
        idle(3);
        chk_voice(0, 20, 100);
        chk_voice(1, 21, 90);
        send_byte(8'd20);
        expect_ev(0, 20, 0);
        send_byte(8'd0);
        idle(3);
        chk_voice(0, 0, 0);
        chk_voice(1, 21, 90);

        // Other channel ignored
        send_byte(8'h91);
        send_byte(8'd30);
        send_byte(8'd127);
        idle(3);
        chk_voice(0, 0, 0);
        chk_voice(1, 21, 90);
        chk_voice(2, 0, 0);

        // Program Change with running status
        send_byte(8'hC0);
        send_byte(8'd5);
        idle(1);
        chk("program", {25'd0, program_num}, 5);
        send_byte(8'd9);
        idle(1);
        chk("program_running", {25'd0, program_num}, 9);

        // Realtime byte mid-message, and pulse hold while ce=0
        send_byte(8'h90);
        send_byte(8'd40);
        send_byte(8'hF8);
        expect_ev(1, 40, 50);
        send_byte(8'd50);
        ce = 1'b0;
        idle(2);
        chk("pulse_hold", {31'd0, note_on_out}, 1);
        chk_voice(0, 0, 0);
        ce = 1'b1;
        idle(3);
        chk_voice(0, 40, 50);

        // ce=0: bytes not accepted
        ce = 1'b0;
        send_byte(8'd60);
        send_byte(8'd127);
        ce = 1'b1;
        idle(3);
        chk_voice(2, 0, 0);
        chk("ce_low_note_num", {25'd0, note_num}, 40);

        // System common byte drops running status
        send_byte(8'hF0);
        send_byte(8'd61);
        send_byte(8'd100);
        idle(3);
        chk_voice(2, 0, 0);

        // Reset between note and velocity bytes
        send_byte(8'h90);
        send_byte(8'd70);
        do_reset();
        send_byte(8'd5);
        send_byte(8'd6);
        idle(3);
        chk_all_zero("post_reset");

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
